eth_phy_10g_rx_bitslip: RTL and testbench

Receive-side bitslip gearbox for the 10G PHY. It accepts raw 66-bit words from the deserializer and presents a realigned 66-bit window to the RX frame-sync and decoder path. It is the responder to the frame-sync `serdes_rx_bitslip` request: each accepted slip request moves the window by one bit, wrapping after 66 positions. It sits between the SERDES model or transceiver and the `serdes_rx` input of the PHY.

---
 rtl/eth_phy_10g_pkg.sv | 15 +
 rtl/eth_phy_10g_rx_slip_ctrl.sv | 58 +++++
 rtl/eth_phy_10g_rx_bitslip.sv | 91 +++++++++
 tb/tb_eth_phy_10g_rx_bitslip.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared 10G PHY constants: block geometry, sync headers and bitslip offset range.
package eth_phy_10g_pkg;

   localparam int unsigned DATA_WIDTH  = 64;
   localparam int unsigned HDR_WIDTH   = 2;
   localparam int unsigned FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH;
   localparam int unsigned HIST_WIDTH  = 2 * FRAME_WIDTH;
   localparam int unsigned OFFSET_W    = 7;

   localparam logic [HDR_WIDTH-1:0] SYNC_DATA = 2'b10;
   localparam logic [HDR_WIDTH-1:0] SYNC_CTRL = 2'b01;

   localparam logic [OFFSET_W-1:0] SLIP_OFFSET_MAX = 7'd65;

endpackage : eth_phy_10g_pkg

// File: rtl/eth_phy_10g_rx_slip_ctrl.sv
// Bitslip request handler: rising-edge detect, holdoff window, wrapping offset
// counter and a one-cycle acknowledge for each accepted slip.
module eth_phy_10g_rx_slip_ctrl
   import eth_phy_10g_pkg::*;
#(
   parameter int unsigned SLIP_HOLDOFF = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                bitslip_i,
   output logic [OFFSET_W-1:0] offset_o,
   output logic                ack_o
);

   localparam int unsigned HOLD_W = $clog2(SLIP_HOLDOFF + 1);

   logic                bitslip_q;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [OFFSET_W-1:0] offset_q, offset_d;
   logic                ack_q, ack_d;
   logic                edge_s;
   logic                accept_s;

   // Edges arriving during holdoff are dropped, not queued.
   always_comb begin
      edge_s   = bitslip_i & ~bitslip_q;
      accept_s = edge_s && (hold_q == HOLD_W'(0));
      offset_d = offset_q;
      hold_d   = hold_q;
      ack_d    = accept_s;
      if (accept_s) begin
         offset_d = (offset_q == SLIP_OFFSET_MAX) ? 7'd0 : offset_q + 7'd1;
         hold_d   = HOLD_W'(SLIP_HOLDOFF);
      end else if (hold_q != HOLD_W'(0)) begin
         hold_d = hold_q - HOLD_W'(1);
      end else begin
         hold_d = hold_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         bitslip_q <= 1'b0;
         hold_q    <= HOLD_W'(0);
         offset_q  <= 7'd0;
         ack_q     <= 1'b0;
      end else begin
         bitslip_q <= bitslip_i;
         hold_q    <= hold_d;
         offset_q  <= offset_d;
         ack_q     <= ack_d;
      end
   end

   assign offset_o = offset_q;
   assign ack_o    = ack_q;

endmodule : eth_phy_10g_rx_slip_ctrl

// File: rtl/eth_phy_10g_rx_bitslip.sv
// RX bitslip gearbox: keeps a two-word history and registers a 66-bit window
// selected by the slip offset, presented as header plus payload.
module eth_phy_10g_rx_bitslip
   import eth_phy_10g_pkg::*;
#(
   parameter int unsigned SLIP_HOLDOFF = 8
) (
   input  logic                   rx_clk,
   input  logic                   rx_rst_n,
   input  logic [FRAME_WIDTH-1:0] in_frame,
   input  logic                   in_valid,
   input  logic                   bitslip,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [HDR_WIDTH-1:0]   out_hdr,
   output logic                   out_valid,
   output logic [OFFSET_W-1:0]    slip_offset,
   output logic                   slip_ack
);

   logic [FRAME_WIDTH-1:0] cur_q, cur_d;
   logic [FRAME_WIDTH-1:0] prev_q, prev_d;
   logic [1:0]             fill_q, fill_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic [HDR_WIDTH-1:0]   hdr_q, hdr_d;
   logic                   valid_q, valid_d;
   logic [HIST_WIDTH-1:0]  hist_s;
   logic [7:0]             sel_s;
   logic [FRAME_WIDTH-1:0] window_s;

   eth_phy_10g_rx_slip_ctrl #(
      .SLIP_HOLDOFF (SLIP_HOLDOFF)
   ) u_slip_ctrl (
      .clk_i     (rx_clk),
      .rst_ni    (rx_rst_n),
      .bitslip_i (bitslip),
      .offset_o  (slip_offset),
      .ack_o     (slip_ack)
   );

   // The window is taken from the updated history but the pre-edge offset,
   // so a slip accepted this cycle only affects the following output.
   always_comb begin
      if (in_valid) begin
         cur_d  = in_frame;
         prev_d = cur_q;
      end else begin
         cur_d  = cur_q;
         prev_d = prev_q;
      end
      if (in_valid && (fill_q != 2'd2)) begin
         fill_d = fill_q + 2'd1;
      end else begin
         fill_d = fill_q;
      end
      hist_s   = {cur_d, prev_d};
      sel_s    = {1'b0, slip_offset};
      window_s = hist_s[sel_s +: FRAME_WIDTH];
      if (in_valid && (fill_d == 2'd2)) begin
         valid_d = 1'b1;
         hdr_d   = window_s[HDR_WIDTH-1:0];
         data_d  = window_s[FRAME_WIDTH-1:HDR_WIDTH];
      end else begin
         valid_d = 1'b0;
         hdr_d   = hdr_q;
         data_d  = data_q;
      end
   end

   always_ff @(posedge rx_clk) begin
      if (!rx_rst_n) begin
         cur_q   <= '0;
         prev_q  <= '0;
         fill_q  <= 2'd0;
         data_q  <= '0;
         hdr_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cur_q   <= cur_d;
         prev_q  <= prev_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         hdr_q   <= hdr_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_hdr   = hdr_q;
   assign out_valid = valid_q;

endmodule : eth_phy_10g_rx_bitslip

// File: tb/tb_eth_phy_10g_rx_bitslip.sv
// Directed self-checking bench for the RX bitslip gearbox.
module tb_eth_phy_10g_rx_bitslip;
   import eth_phy_10g_pkg::*;

   localparam int unsigned HOLDOFF = 8;
   localparam logic [65:0] PASS_FRAME = {64'h0123456789ABCDEF, 2'b01};
   localparam logic [65:0] ONE_FRAME  = {64'h0, 2'b01};

   logic        rx_clk = 1'b0;
   logic        rx_rst_n;
   logic [65:0] in_frame;
   logic        in_valid;
   logic        bitslip;
   logic [63:0] out_data;
   logic [1:0]  out_hdr;
   logic        out_valid;
   logic [6:0]  slip_offset;
   logic        slip_ack;

   int checks = 0;
   int errors = 0;
   logic [6:0] exp_off = 7'd0;

   eth_phy_10g_rx_bitslip #(.SLIP_HOLDOFF(HOLDOFF)) dut (
      .rx_clk      (rx_clk),
      .rx_rst_n    (rx_rst_n),
      .in_frame    (in_frame),
      .in_valid    (in_valid),
      .bitslip     (bitslip),
      .out_data    (out_data),
      .out_hdr     (out_hdr),
      .out_valid   (out_valid),
      .slip_offset (slip_offset),
      .slip_ack    (slip_ack)
   );

   always #5 rx_clk = ~rx_clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge rx_clk);
         #1;
      end
   endtask

   // One accepted slip pulse followed by enough idle cycles to clear holdoff.
   task automatic pulse_slip(input string name);
      bitslip = 1'b1;
      step(1);
      exp_off = (exp_off == 7'd65) ? 7'd0 : exp_off + 7'd1;
      checks++;
      if (slip_offset !== exp_off || slip_ack !== 1'b1) begin
         errors++;
         $display("FAIL %s: offset=%0d ack=%b, expected offset=%0d ack=1", name, slip_offset, slip_ack, exp_off);
      end
      bitslip = 1'b0;
      step(HOLDOFF + 1);
   endtask

   task automatic test_reset;
      rx_rst_n = 1'b0;
      in_valid = 1'b1;
      in_frame = PASS_FRAME;
      bitslip  = 1'b0;
      step(3);
      checks++;
      if ({out_data, out_hdr, out_valid, slip_offset, slip_ack} !== 75'd0) begin
         errors++;
         $display("FAIL reset_outputs: data=%h hdr=%b valid=%b off=%0d ack=%b, expected all 0",
                  out_data, out_hdr, out_valid, slip_offset, slip_ack);
      end
      rx_rst_n = 1'b1;
      step(1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_first_word: out_valid=%b, expected 0", out_valid);
      end
      step(1);
      checks++;
      if (out_valid !== 1'b1 || slip_offset !== 7'd0) begin
         errors++;
         $display("FAIL fill_second_word: out_valid=%b off=%0d, expected 1 and 0", out_valid, slip_offset);
      end
   endtask

   task automatic test_passthrough;
      in_frame = PASS_FRAME;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++;
         if (out_valid !== 1'b1 || out_hdr !== 2'b01 || out_data !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL passthrough[%0d]: valid=%b hdr=%b data=%h, expected 1 01 0123456789abcdef",
                     i, out_valid, out_hdr, out_data);
         end
      end
      in_valid = 1'b0;
      in_frame = 66'h3_FFFF_FFFF_FFFF_FFFF;
      step(1);
      checks++;
      if (out_valid !== 1'b0 || out_hdr !== 2'b01 || out_data !== 64'h0123456789ABCDEF) begin
         errors++;
         $display("FAIL idle_hold: valid=%b hdr=%b data=%h, expected 0 01 0123456789abcdef",
                  out_valid, out_hdr, out_data);
      end
      in_valid = 1'b1;
      in_frame = PASS_FRAME;
      step(2);
   endtask

   task automatic test_single_slip;
      in_frame = ONE_FRAME;
      step(2);
      bitslip = 1'b1;
      step(1);
      exp_off = 7'd1;
      checks++;
      if (slip_ack !== 1'b1 || slip_offset !== 7'd1) begin
         errors++;
         $display("FAIL slip_accept: ack=%b off=%0d, expected 1 and 1", slip_ack, slip_offset);
      end
      checks++;
      if (out_hdr !== 2'b01 || out_data !== 64'h0) begin
         errors++;
         $display("FAIL slip_same_cycle_old_offset: hdr=%b data=%h, expected 01 0", out_hdr, out_data);
      end
      bitslip = 1'b0;
      step(1);
      checks++;
      if (slip_ack !== 1'b0 || out_hdr !== 2'b00 || out_data !== 64'h8000000000000000) begin
         errors++;
         $display("FAIL slip_shifted: ack=%b hdr=%b data=%h, expected 0 00 8000000000000000",
                  slip_ack, out_hdr, out_data);
      end
      step(HOLDOFF);
   endtask

   task automatic test_wrap;
      in_frame = ONE_FRAME;
      while (exp_off != 7'd65) pulse_slip("wrap_step");
      checks++;
      if (out_hdr !== 2'b10 || out_data !== 64'h0 || slip_offset !== 7'd65) begin
         errors++;
         $display("FAIL offset65_window: hdr=%b data=%h off=%0d, expected 10 0 65", out_hdr, out_data, slip_offset);
      end
      pulse_slip("wrap_to_zero");
      in_frame = PASS_FRAME;
      step(2);
      checks++;
      if (slip_offset !== 7'd0 || out_hdr !== 2'b01 || out_data !== 64'h0123456789ABCDEF) begin
         errors++;
         $display("FAIL wrap_passthrough: off=%0d hdr=%b data=%h, expected 0 01 0123456789abcdef",
                  slip_offset, out_hdr, out_data);
      end
   endtask

   task automatic test_holdoff;
      int acks;
      acks = 0;
      bitslip = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (slip_ack === 1'b1) acks++;
      end
      bitslip = 1'b0;
      step(HOLDOFF + 1);
      exp_off = 7'd1;
      checks++;
      if (acks !== 1 || slip_offset !== 7'd1) begin
         errors++;
         $display("FAIL level_high: acks=%0d off=%0d, expected 1 and 1", acks, slip_offset);
      end
      acks = 0;
      for (int i = 0; i < 16; i++) begin
         bitslip = (i == 0 || i == 3) ? 1'b1 : 1'b0;
         step(1);
         if (slip_ack === 1'b1) acks++;
      end
      exp_off = 7'd2;
      checks++;
      if (acks !== 1 || slip_offset !== 7'd2) begin
         errors++;
         $display("FAIL edge_in_holdoff: acks=%0d off=%0d, expected 1 and 2", acks, slip_offset);
      end
   endtask

   task automatic test_mid_reset;
      in_frame = ONE_FRAME;
      while (exp_off != 7'd17) pulse_slip("to_17");
      rx_rst_n = 1'b0;
      step(1);
      exp_off = 7'd0;
      checks++;
      if (slip_offset !== 7'd0 || out_valid !== 1'b0 || slip_ack !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: off=%0d valid=%b ack=%b, expected 0 0 0", slip_offset, out_valid, slip_ack);
      end
      rx_rst_n = 1'b1;
      in_frame = PASS_FRAME;
      step(1);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_first_word: out_valid=%b, expected 0", out_valid);
      end
      step(1);
      checks++;
      if (out_valid !== 1'b1 || out_hdr !== 2'b01 || out_data !== 64'h0123456789ABCDEF) begin
         errors++;
         $display("FAIL post_reset_second_word: valid=%b hdr=%b data=%h, expected 1 01 0123456789abcdef",
                  out_valid, out_hdr, out_data);
      end
   endtask

   initial begin
      rx_rst_n = 1'b0;
      in_frame = '0;
      in_valid = 1'b0;
      bitslip  = 1'b0;
      test_reset();
      test_passthrough();
      test_single_slip();
      test_wrap();
      test_holdoff();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_eth_phy_10g_rx_bitslip
